// File: rtl/qspi_bus_bridge_if.sv
// -----------------------------------------------------------------------------
// qspi_bus_bridge_if
// Purpose : bundles the CPU load/store handshake and the downstream qspi_if
//           request/response signals of the QSPI bus bridge.
// Modports:
//   slave  - the bridge: receives CPU requests and qspi_if completions,
//            drives CPU responses and qspi_if requests.
//   master - the environment (CPU plus qspi_if): the mirror image of slave.
// Signals :
//   cpu_req/cpu_we/cpu_size/cpu_unsigned/cpu_adr/cpu_wdata  CPU request
//   cpu_ack/cpu_err/cpu_rdata/cpu_busy                      CPU response
//   read_req/write_req, read_w/read_hw/write_w/write_hw,
//   read_adr/write_adr/write_data                           to qspi_if
//   read_valid/read_data/write_finish                       from qspi_if
// -----------------------------------------------------------------------------
interface qspi_bus_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_adr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        cpu_busy;
  logic        read_req;
  logic        write_req;
  logic        read_w;
  logic        read_hw;
  logic        write_w;
  logic        write_hw;
  logic [31:0] read_adr;
  logic [31:0] write_adr;
  logic [31:0] write_data;
  logic        read_valid;
  logic [31:0] read_data;
  logic        write_finish;

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_adr, cpu_wdata,
    input  read_valid, read_data, write_finish,
    output cpu_ack, cpu_err, cpu_rdata, cpu_busy,
    output read_req, write_req, read_w, read_hw, write_w, write_hw,
    output read_adr, write_adr, write_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_adr, cpu_wdata,
    output read_valid, read_data, write_finish,
    input  cpu_ack, cpu_err, cpu_rdata, cpu_busy,
    input  read_req, write_req, read_w, read_hw, write_w, write_hw,
    input  read_adr, write_adr, write_data
  );
endinterface

// File: rtl/qspi_bus_bridge.sv
// -----------------------------------------------------------------------------
// qspi_bus_bridge
// Purpose : CPU load/store front end for the QSPI flash/PSRAM controller.
//           Accepts one request at a time, checks size/alignment/address
//           window, issues a one-cycle read_req/write_req to qspi_if, holds
//           address/size/data stable, and answers with extended load data
//           (cpu_ack) or an error pulse (cpu_err, no flash access made).
// Ports   :
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - qspi_bus_bridge_if.slave (CPU side and qspi_if side)
// Parameters:
//   BASE_ADR - base of the QSPI address window
//   ADR_BITS - window size in address bits
// Build option:
//   QSPI_RDBUF_EN - adds a one-entry word read buffer; loads hitting it are
//                   answered without a flash access.
// Timing  : every output is a flop updated from the next state, so each
//           pulse lines up with the state it belongs to. read_valid and
//           write_finish are captured in an input register first, which is
//           why cpu_ack comes two cycles after a completion pulse.
// -----------------------------------------------------------------------------
module qspi_bus_bridge #(
  parameter logic [31:0] BASE_ADR = 32'h0100_0000,
  parameter int unsigned ADR_BITS = 24
) (
  input logic              clk,
  input logic              rst_n,
  qspi_bus_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERR     = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WR_REQ  = 3'd4,
    S_WR_WAIT = 3'd5,
    S_RESP    = 3'd6
  } state_e;

  // Sign/zero-extends right-aligned load data according to the access size.
  function automatic logic [31:0] extend_load(input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] ext;
    case (size)
      2'b00:   ext = uns ? {24'd0, data[7:0]}  : {{24{data[7]}},  data[7:0]};
      2'b01:   ext = uns ? {16'd0, data[15:0]} : {{16{data[15]}}, data[15:0]};
      default: ext = data;
    endcase
    return ext;
  endfunction

`ifdef QSPI_RDBUF_EN
  // Picks the addressed byte/halfword lane out of a buffered word.
  function automatic logic [31:0] lane_select(input logic [31:0] data,
                                              input logic [1:0]  lo,
                                              input logic [1:0]  size);
    logic [31:0] lane;
    case (size)
      2'b00:   lane = {24'd0, data[{lo, 3'b000} +: 8]};
      2'b01:   lane = {16'd0, data[{lo[1], 4'b0000} +: 16]};
      default: lane = data;
    endcase
    return lane;
  endfunction
`endif

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [23:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        read_w_q, read_w_d;
  logic        read_hw_q, read_hw_d;
  logic        write_w_q, write_w_d;
  logic        write_hw_q, write_hw_d;
  logic        ack_q, err_q, rreq_q, wreq_q, busy_q;
  logic        rv_q, wf_q;
  logic [31:0] rd_in_q;
  logic        align_err_s, win_err_s, req_err_s;

`ifdef QSPI_RDBUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [21:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        buf_hit_s;
`endif

  // Request legality: reserved size, misalignment, or outside the window.
  always_comb begin
    case (bus.cpu_size)
      2'b00:   align_err_s = 1'b0;
      2'b01:   align_err_s = bus.cpu_adr[0];
      2'b10:   align_err_s = (bus.cpu_adr[1:0] != 2'b00);
      default: align_err_s = 1'b1;
    endcase
    win_err_s = ((bus.cpu_adr >> ADR_BITS) != (BASE_ADR >> ADR_BITS));
    req_err_s = align_err_s | win_err_s;
  end

`ifdef QSPI_RDBUF_EN
  assign buf_hit_s = buf_valid_q && (buf_tag_q == bus.cpu_adr[23:2]);
`endif

  // Next-state, request latching and load-data formatting.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    uns_d      = uns_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    read_w_d   = read_w_q;
    read_hw_d  = read_hw_q;
    write_w_d  = write_w_q;
    write_hw_d = write_hw_q;
`ifdef QSPI_RDBUF_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          size_d     = bus.cpu_size;
          uns_d      = bus.cpu_unsigned;
          adr_d      = bus.cpu_adr[23:0];
          wdata_d    = bus.cpu_wdata;
          read_w_d   = !bus.cpu_we && (bus.cpu_size == 2'b10);
          read_hw_d  = !bus.cpu_we && (bus.cpu_size == 2'b01);
          write_w_d  = bus.cpu_we && (bus.cpu_size == 2'b10);
          write_hw_d = bus.cpu_we && (bus.cpu_size == 2'b01);
          if (req_err_s) begin
            state_d = S_ERR;
          end else if (bus.cpu_we) begin
            state_d = S_WR_REQ;
`ifdef QSPI_RDBUF_EN
            // A store to the buffered word makes the copy stale.
            if (buf_tag_q == bus.cpu_adr[23:2]) begin
              buf_valid_d = 1'b0;
            end else begin
              buf_valid_d = buf_valid_q;
            end
`endif
          end
`ifdef QSPI_RDBUF_EN
          else if (buf_hit_s) begin
            state_d = S_RESP;
            rdata_d = extend_load(lane_select(buf_data_q, bus.cpu_adr[1:0], bus.cpu_size),
                                  bus.cpu_size, bus.cpu_unsigned);
          end
`endif
          else begin
            state_d = S_RD_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR:    state_d = S_IDLE;
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (rv_q) begin
          rdata_d = extend_load(rd_in_q, size_q, uns_q);
          state_d = S_RESP;
`ifdef QSPI_RDBUF_EN
          if (size_q == 2'b10) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = adr_q[23:2];
            buf_data_d  = rd_in_q;
          end else begin
            buf_valid_d = buf_valid_q;
          end
`endif
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_WR_REQ: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (wf_q) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WR_WAIT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request, output flops and qspi_if completion capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      adr_q      <= 24'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      read_w_q   <= 1'b0;
      read_hw_q  <= 1'b0;
      write_w_q  <= 1'b0;
      write_hw_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rreq_q     <= 1'b0;
      wreq_q     <= 1'b0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      wf_q       <= 1'b0;
      rd_in_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      read_w_q   <= read_w_d;
      read_hw_q  <= read_hw_d;
      write_w_q  <= write_w_d;
      write_hw_q <= write_hw_d;
      ack_q      <= (state_d == S_RESP);
      err_q      <= (state_d == S_ERR);
      rreq_q     <= (state_d == S_RD_REQ);
      wreq_q     <= (state_d == S_WR_REQ);
      busy_q     <= (state_d != S_IDLE);
      // Completions count only while waiting for them; strays are dropped here.
      rv_q       <= (state_q == S_RD_WAIT) && bus.read_valid;
      wf_q       <= (state_q == S_WR_WAIT) && bus.write_finish;
      if ((state_q == S_RD_WAIT) && bus.read_valid) begin
        rd_in_q <= bus.read_data;
      end
    end
  end

`ifdef QSPI_RDBUF_EN
  // One-entry word read buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= 22'd0;
      buf_data_q  <= 32'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

  assign bus.cpu_ack    = ack_q;
  assign bus.cpu_err    = err_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_busy   = busy_q;
  assign bus.read_req   = rreq_q;
  assign bus.write_req  = wreq_q;
  assign bus.read_w     = read_w_q;
  assign bus.read_hw    = read_hw_q;
  assign bus.write_w    = write_w_q;
  assign bus.write_hw   = write_hw_q;
  assign bus.read_adr   = {8'd0, adr_q};
  assign bus.write_adr  = {8'd0, adr_q};
  assign bus.write_data = wdata_q;

endmodule
